// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-TX-side handshake signals of the arbiter.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        input  req_valid, req_data, tx_busy, tx_done,
        output req_ready, tx_start, tx_data
    );

    modport slave (
        output req_valid, req_data, tx_busy, tx_done,
        input  req_ready, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-wide UART transmitter among NUM_REQ requesters,
// with a per-transfer timeout and a sticky timeout error flag.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TO_W    = 16,
    parameter int TIMEOUT = 16384,
    localparam int GID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    uart_tx_arbiter_if.master      bus,
    output logic [GID_W-1:0]       grant_id,
    output logic                   active,
    output logic                   timeout_err,
    input  logic                   err_clear,
    output logic [1:0]             dbg_state
);
    // Requester handshake: req_valid[i] is held with a stable req_data byte until
    // req_ready[i] pulses for one cycle, which is the accept. UART side: tx_start is a
    // level held until tx_busy is sampled; tx_done is a one-cycle end-of-frame pulse.

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

    state_t             state_q,  state_d;
    logic [GID_W-1:0]   ptr_q,    ptr_d;
    logic [TO_W-1:0]    cnt_q,    cnt_d;
    logic [7:0]         data_q,   data_d;
    logic [GID_W-1:0]   gid_q,    gid_d;
    logic               active_q, active_d;
    logic               start_q,  start_d;
    logic [NUM_REQ-1:0] ready_q,  ready_d;
    logic               err_q,    err_d;

    logic               found;
    logic [GID_W-1:0]   sel;
    logic               timeout_hit;

    // First valid requester scanning upward from the pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                sel   = GID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        gid_d       = gid_q;
        active_d    = active_q;
        start_d     = start_q;
        ready_d     = '0;
        err_d       = err_q;
        timeout_hit = 1'b0;
        if (err_clear) err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    ready_d  = NUM_REQ'(1) << sel;
                    data_d   = bus.req_data[8*int'(sel) +: 8];
                    gid_d    = sel;
                    start_d  = 1'b1;
                    active_d = 1'b1;
                    cnt_d    = '0;
                    ptr_d    = (int'(sel) == NUM_REQ - 1) ? '0 : sel + 1'b1;
                    state_d  = START;
                end
            end
            START: begin
                // tx_done is meaningless before the UART has acknowledged with busy.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    timeout_hit = 1'b1;
                end else if (bus.tx_busy) begin
                    start_d = 1'b0;
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.tx_done) begin
                    active_d = 1'b0;
                    state_d  = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_hit = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort drops the byte; the pointer already moved past this requester.
        if (timeout_hit) begin
            start_d  = 1'b0;
            active_d = 1'b0;
            err_d    = 1'b1;
            state_d  = IDLE;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            gid_q    <= '0;
            active_q <= 1'b0;
            start_q  <= 1'b0;
            ready_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            gid_q    <= gid_d;
            active_q <= active_d;
            start_q  <= start_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.tx_start  = start_q;
    assign bus.tx_data   = data_q;
    assign grant_id      = gid_q;
    assign active        = active_q;
    assign timeout_err   = err_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single byte, round-robin order, hold-until-busy,
// timeout, done/timeout collision and reset mid-frame.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ = 4;
    localparam int TO_W    = 16;
    localparam int TIMEOUT = 64;

    localparam logic [31:0] S_IDLE  = 32'd0;
    localparam logic [31:0] S_START = 32'd1;
    localparam logic [31:0] S_WAIT  = 32'd2;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] grant_id;
    logic       active;
    logic       timeout_err;
    logic       err_clear;
    logic [1:0] dbg_state;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .bus         (bus.master),
        .grant_id    (grant_id),
        .active      (active),
        .timeout_err (timeout_err),
        .err_clear   (err_clear),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".ready"},  32'(bus.req_ready), 32'h0);
        check({tag, ".start"},  32'(bus.tx_start),  32'h0);
        check({tag, ".active"}, 32'(active),        32'h0);
        check({tag, ".state"},  32'(dbg_state),     S_IDLE);
    endtask

    // Waits for an accept, checks it, optionally keeps the requester valid with a new
    // byte, then plays the UART: one busy cycle, then a done pulse.
    task automatic serve(input string tag, input int gid, input logic [7:0] data,
                         input bit refill, input logic [7:0] refill_data);
        int n = 0;
        while (bus.req_ready == '0 && n < 10) begin
            tick();
            n++;
        end
        check({tag, ".ready"}, 32'(bus.req_ready), 32'(1) << gid);
        check({tag, ".data"},  32'(bus.tx_data),   32'(data));
        check({tag, ".gid"},   32'(grant_id),      32'(gid));
        check({tag, ".start"}, 32'(bus.tx_start),  32'h1);
        if (refill) bus.req_data[8*gid +: 8] = refill_data;
        else        bus.req_valid[gid] = 1'b0;
        bus.tx_busy = 1'b1;
        tick();
        bus.tx_busy = 1'b0;
        check({tag, ".start_drop"}, 32'(bus.tx_start), 32'h0);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        check({tag, ".active_drop"}, 32'(active), 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int hold;
        rst           = 1'b1;
        err_clear     = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.tx_busy   = 1'b0;
        bus.tx_done   = 1'b0;
        do_reset();

        check_idle_outputs("reset");
        check("reset.data", 32'(bus.tx_data), 32'h0);
        check("reset.gid",  32'(grant_id),    32'h0);
        check("reset.err",  32'(timeout_err), 32'h0);

        // Single byte from requester 2.
        bus.req_valid          = 4'b0100;
        bus.req_data[23:16]    = 8'h41;
        tick();
        check("single.ready", 32'(bus.req_ready), 32'h4);
        check("single.start", 32'(bus.tx_start),  32'h1);
        check("single.data",  32'(bus.tx_data),   32'h41);
        check("single.gid",   32'(grant_id),      32'h2);
        check("single.state", 32'(dbg_state),     S_START);
        bus.req_valid = '0;
        tick();
        check("single.ready_pulse", 32'(bus.req_ready), 32'h0);
        check("single.start_hold",  32'(bus.tx_start),  32'h1);
        bus.tx_busy = 1'b1;
        tick();
        bus.tx_busy = 1'b0;
        check("single.start_drop", 32'(bus.tx_start), 32'h0);
        check("single.state_wait", 32'(dbg_state),    S_WAIT);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        check_idle_outputs("single.end");
        check("single.data_held", 32'(bus.tx_data), 32'h41);

        // Round robin from pointer 0; requester 0 refilled after its first grant.
        do_reset();
        bus.req_valid = 4'b1111;
        bus.req_data  = 32'h33323130;
        serve("rr0", 0, 8'h30, 1'b1, 8'h34);
        serve("rr1", 1, 8'h31, 1'b0, 8'h00);
        serve("rr2", 2, 8'h32, 1'b0, 8'h00);
        serve("rr3", 3, 8'h33, 1'b0, 8'h00);
        serve("rr4", 0, 8'h34, 1'b0, 8'h00);

        // Hold-until-busy: 20 cycles without busy, an early tx_done in between.
        bus.req_valid       = 4'b0010;
        bus.req_data[15:8]  = 8'h55;
        tick();
        check("hold.ready", 32'(bus.req_ready), 32'h2);
        bus.req_valid = '0;
        hold = 0;
        for (int i = 0; i < 20; i++) begin
            bus.tx_done = (i == 5);
            if (bus.tx_start) hold++;
            tick();
        end
        bus.tx_done = 1'b0;
        check("hold.cycles", 32'(hold),      32'd20);
        check("hold.state",  32'(dbg_state), S_START);
        check("hold.active", 32'(active),    32'h1);
        bus.tx_busy = 1'b1;
        tick();
        bus.tx_busy = 1'b0;
        check("hold.start_drop", 32'(bus.tx_start), 32'h0);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        check_idle_outputs("hold.end");

        // Timeout on requester 3 with err_clear held (set wins); requester 0 pending.
        bus.req_valid        = 4'b1001;
        bus.req_data[31:24]  = 8'h66;
        bus.req_data[7:0]    = 8'h77;
        tick();
        check("to.gid", 32'(grant_id), 32'h3);
        bus.req_valid[3] = 1'b0;
        err_clear = 1'b1;
        n = 0;
        while (bus.tx_start && n < 200) begin
            tick();
            n++;
        end
        err_clear = 1'b0;
        check("to.cycles", 32'(n),           32'(TIMEOUT));
        check("to.err",    32'(timeout_err), 32'h1);
        check("to.active", 32'(active),      32'h0);
        check("to.state",  32'(dbg_state),   S_IDLE);
        tick();
        check("to.next_ready", 32'(bus.req_ready), 32'h1);
        check("to.next_data",  32'(bus.tx_data),   32'h77);
        check("to.err_sticky", 32'(timeout_err),   32'h1);
        bus.req_valid = '0;
        err_clear     = 1'b1;
        bus.tx_busy   = 1'b1;
        tick();
        err_clear   = 1'b0;
        bus.tx_busy = 1'b0;
        check("to.err_clear", 32'(timeout_err), 32'h0);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        check_idle_outputs("to.end");

        // Done on the last allowed cycle wins over timeout.
        bus.req_valid       = 4'b0010;
        bus.req_data[15:8]  = 8'h88;
        tick();
        check("col.gid", 32'(grant_id), 32'h1);
        bus.req_valid = '0;
        bus.tx_busy   = 1'b1;
        tick();
        bus.tx_busy = 1'b0;
        for (int i = 0; i < TIMEOUT - 2; i++) tick();
        check("col.active_before", 32'(active),    32'h1);
        check("col.state_before",  32'(dbg_state), S_WAIT);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        check("col.err", 32'(timeout_err), 32'h0);
        check_idle_outputs("col.end");

        // Reset during WAIT_DONE, then a late tx_done.
        bus.req_valid       = 4'b0100;
        bus.req_data[23:16] = 8'h99;
        tick();
        check("rst.gid", 32'(grant_id), 32'h2);
        bus.req_valid = '0;
        bus.tx_busy   = 1'b1;
        tick();
        check("rst.state_wait", 32'(dbg_state), S_WAIT);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.tx_busy = 1'b0;
        check_idle_outputs("rst.mid");
        check("rst.data", 32'(bus.tx_data), 32'h0);
        check("rst.gid0", 32'(grant_id),    32'h0);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        tick();
        check_idle_outputs("rst.late_done");
        check("rst.late_err", 32'(timeout_err), 32'h0);
        // Pointer back at 0: requesters 1 and 3 pending, 1 must win.
        bus.req_valid = 4'b1010;
        bus.req_data  = 32'hA0_00_A1_00;
        serve("rst.ptr1", 1, 8'hA1, 1'b0, 8'h00);
        serve("rst.ptr3", 3, 8'hA0, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one byte-wide UART transmitter among NUM_REQ requesters (CPU mailbox, debug logger, loopback path, etc.).
- Accepts one byte from the winning requester and drives the transmitter's tx_start/tx_data handshake.
- Waits for the transmitter's busy/done indications, then re-arbitrates.
- Sits between the requesters and the UART TX engine, in the user-project clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (1..8).
- TO_W, 16, width of the per-transfer timeout counter.
- TIMEOUT, 16384, cycles allowed from tx_start assertion to tx_done before abort (TIMEOUT < 2**TO_W).

Ports:
- wb_clk_i  input  1  system clock, all logic on rising edge.
- wb_rst_i  input  1  synchronous active-high reset.
- req_valid  input  NUM_REQ  requester i has a byte pending; held until its req_ready pulse.
- req_data  input  8*NUM_REQ  byte of requester i at bits [8i+7:8i]; stable while req_valid[i].
- req_ready  output  NUM_REQ  one-cycle accept pulse to the granted requester.
- tx_start  output  1  start request to UART TX; level, held until tx_busy seen.
- tx_data  output  8  byte to transmit; stable from accept until return to IDLE.
- tx_busy  input  1  UART TX frame in progress.
- tx_done  input  1  UART TX end-of-frame pulse (clear request).
- grant_id  output  $clog2(NUM_REQ) (min 1)  index of current/last granted requester.
- active  output  1  high from accept until transfer completes or aborts.
- timeout_err  output  1  sticky: a transfer aborted on timeout.
- err_clear  input  1  clears timeout_err.

Behaviour:
- Reset (sampled on wb_clk_i edge while wb_rst_i=1):
  - state IDLE; req_ready=0, tx_start=0, tx_data=0, grant_id=0, active=0, timeout_err=0.
  - Round-robin pointer=0; timeout counter=0.
- State IDLE:
  - If any req_valid is set, select the first set bit scanning from the pointer upward, wrapping modulo NUM_REQ.
  - On that edge: req_ready[sel]<=1 (one cycle only), tx_data<=req_data[sel], grant_id<=sel, tx_start<=1, active<=1, counter<=0, pointer<=(sel+1) mod NUM_REQ, state<=START.
  - Latency: req_valid sampled at edge N gives req_ready and tx_start high after edge N.
  - If no req_valid is set, outputs hold and req_ready=0.
- State START:
  - tx_start stays 1; counter increments each cycle.
  - When tx_busy=1 is sampled: tx_start<=0, state<=WAIT_DONE.
  - tx_done in this state is ignored.
- State WAIT_DONE:
  - Counter keeps incrementing.
  - When tx_done=1 is sampled: active<=0, state<=IDLE. Re-arbitration occurs on the following edge; minimum one IDLE cycle between transfers.
- Timeout:
  - In START or WAIT_DONE, if counter==TIMEOUT-1 and tx_done=0: tx_start<=0, active<=0, timeout_err<=1, state<=IDLE.
  - The byte is dropped with no retry. The pointer has already advanced.
  - If tx_done and timeout occur in the same cycle, done wins and no error is flagged.
- timeout_err:
  - Cleared by err_clear=1.
  - If set and clear occur in the same cycle, set wins.
- Requesters:
  - A requester that drops req_valid before being granted is simply skipped.
  - req_valid still high on the cycle after req_ready is treated as a new byte.
- Fairness: with all requesters valid, grants are issued in order 0,1,…,NUM_REQ-1,0; no requester waits more than NUM_REQ-1 transfers.
- NUM_REQ=1: pointer is constant 0 and grant_id=0.
- Reset mid-transfer:
  - Immediate return to reset values; tx_start drops.
  - A frame already started in the UART is not aborted. Any tx_done arriving later in IDLE is ignored.
- tx_busy and tx_done are treated as synchronous to wb_clk_i; any synchronizer lives outside this block.

Test Plan:
- Single byte: req_valid=4'b0100, req_data[23:16]=8'h41 → req_ready=4'b0100 for one cycle, tx_start=1, tx_data=8'h41, grant_id=2. After tx_busy=1, tx_start=0; after tx_done pulse, active=0.
- Round-robin: all four valid with bytes 8'h30..8'h33 and UART model responding → tx_data sequence 30,31,32,33. With requester 0 refilled after its grant, the next grant goes to 1 before 0.
- Hold-until-busy: delay tx_busy by 20 cycles → tx_start stays high all 20 cycles and drops the cycle after busy is sampled. tx_done before busy is ignored.
- Timeout: TIMEOUT=64, never assert tx_busy → tx_start drops after 64 cycles, timeout_err=1, state IDLE; next pending requester is granted. err_clear=1 → timeout_err=0.
- Done/timeout collision: tx_done asserted on exactly cycle TIMEOUT-1 → timeout_err stays 0, normal completion.
- Reset mid-frame: wb_rst_i=1 during WAIT_DONE → all outputs 0, pointer 0. A late tx_done pulse afterward causes no grant and no error.
